bl_zone_scheduler: RTL

Frame scheduler between the 360-zone backlight statistics stage and the LED driver interface. It captures one value per zone per frame into a ping-pong zone buffer and swaps banks on frame sync. It then streams the completed frame to the driver in zone order over a valid/ready handshake. Capture of frame N+1 therefore never disturbs the transmission of frame N.

---
 rtl/bl_pkg.sv | 27 ++
 rtl/bl_zone_dpram.sv | 28 ++
 rtl/bl_zone_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bl_pkg.sv
// Shared constants, beat record and read-FSM state type for the backlight zone scheduler.
package bl_pkg;

    localparam int ZONES     = 360;
    localparam int DW        = 8;
    localparam int AW        = 9;
    localparam int RAM_DEPTH = 2 * ZONES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SEND  = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } beat_t;

    // Address MSB picks the bank; bank 1 sits directly above the ZONES entries of bank 0.
    function automatic logic [AW:0] bank_phys(input logic [AW:0] addr);
        logic [AW:0] base;
        base = {1'b0, addr[AW-1:0]};
        return addr[AW] ? (base + (AW+1)'(ZONES)) : base;
    endfunction

endpackage

// File: rtl/bl_zone_dpram.sv
// Ping-pong zone store: 2*ZONES x DW simple dual-port RAM with one-cycle registered read.
module bl_zone_dpram
    import bl_pkg::*;
(
    input  logic          i_pix_clk,
    input  logic          wr_en_i,
    input  logic [AW:0]   wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW:0]   rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [0:RAM_DEPTH-1];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge i_pix_clk) begin
        if (wr_en_i) begin
            mem_q[bank_phys(wr_addr_i)] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[bank_phys(rd_addr_i)];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bl_zone_scheduler.sv
// Captures one value per zone per frame into a ping-pong buffer and streams the finished frame
// to the LED driver over valid/ready. Optional global dimming: define BL_GLOBAL_DIM_EN.
module bl_zone_scheduler
    import bl_pkg::*;
(
    input  logic          i_pix_clk,
    input  logic          rst_n,
    input  logic          zone_vld,
    input  logic [AW-1:0] zone_idx,
    input  logic [DW-1:0] zone_val,
    input  logic          frame_sync,
    input  logic [7:0]    dim_level,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_data,
    output logic          out_sof,
    output logic          out_eof,
    output logic          busy,
    output logic          frame_short,
    output logic [7:0]    overrun_cnt
);

    // ---------------- write side ----------------
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [7:0]    overrun_q, overrun_d;
    logic          frame_short_q, frame_short_d;
    logic          wr_en;
    logic [AW-1:0] wr_cnt_inc;
    logic          frame_done;
    logic          swap;

    rd_state_e     state_q, state_d;

    assign wr_en      = zone_vld && (zone_idx < AW'(ZONES));
    // A write in the same cycle as frame_sync still counts toward the ending frame.
    assign wr_cnt_inc = wr_cnt_q + {{(AW-1){1'b0}}, wr_en};
    assign frame_done = frame_sync && (wr_cnt_inc == AW'(ZONES));
    assign swap       = frame_done && (state_q == IDLE);

    always_comb begin
        wr_bank_d     = wr_bank_q ^ swap;
        wr_cnt_d      = frame_sync ? '0 : wr_cnt_inc;
        frame_short_d = frame_sync && !frame_done;
        overrun_d     = overrun_q;
        if (frame_done && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q     <= 1'b0;
            wr_cnt_q      <= '0;
            overrun_q     <= '0;
            frame_short_q <= 1'b0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            wr_cnt_q      <= wr_cnt_d;
            overrun_q     <= overrun_d;
            frame_short_q <= frame_short_d;
        end
    end

    // ---------------- read side ----------------
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          inflight_q;
    logic [AW-1:0] inflight_idx_q;
    logic          head_vld_q, head_vld_d;
    beat_t         head_q, head_d;
    logic          skid_vld_q, skid_vld_d;
    beat_t         skid_q, skid_d;
    logic          issue;
    logic          pop;
    logic [1:0]    occ;
    logic          can_issue;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] load_data;
    beat_t         load_beat;

    assign pop = head_vld_q && out_ready;
    // Head + skid + the read still in the RAM pipe must never exceed the two buffer slots.
    assign occ       = 2'(head_vld_q) + 2'(skid_vld_q) + 2'(inflight_q);
    assign can_issue = (occ - 2'(pop)) <= 2'd1;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                issue   = can_issue;
                state_d = SEND;
            end
            SEND: begin
                issue = (rd_ptr_q < AW'(ZONES)) && can_issue;
                if (pop && (head_q.idx == AW'(ZONES-1))) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (swap) begin
            rd_ptr_d = '0;
        end else if (issue) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    bl_zone_dpram u_dpram (
        .i_pix_clk (i_pix_clk),
        .wr_en_i   (wr_en),
        .wr_addr_i ({wr_bank_q, zone_idx}),
        .wr_data_i (zone_val),
        .rd_en_i   (issue),
        .rd_addr_i ({~wr_bank_q, rd_ptr_q}),
        .rd_data_o (ram_rdata)
    );

`ifdef BL_GLOBAL_DIM_EN
    logic [15:0] dim_prod;
    assign dim_prod  = 16'(ram_rdata) * (16'(dim_level) + 16'd1);
    assign load_data = DW'(dim_prod >> 8);
`else
    logic unused_dim;
    assign unused_dim = ^dim_level;
    assign load_data  = ram_rdata;
`endif

    assign load_beat.idx  = inflight_idx_q;
    assign load_beat.data = load_data;

    always_comb begin
        head_vld_d = head_vld_q;
        head_d     = head_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (!head_vld_q || pop) begin
            if (skid_vld_q) begin
                head_vld_d = 1'b1;
                head_d     = skid_q;
                skid_vld_d = inflight_q;
                if (inflight_q) begin
                    skid_d = load_beat;
                end
            end else begin
                head_vld_d = inflight_q;
                if (inflight_q) begin
                    head_d = load_beat;
                end
            end
        end else if (inflight_q) begin
            skid_vld_d = 1'b1;
            skid_d     = load_beat;
        end
    end

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            head_vld_q     <= 1'b0;
            head_q         <= '0;
            skid_vld_q     <= 1'b0;
            skid_q         <= '0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            inflight_q     <= issue;
            inflight_idx_q <= rd_ptr_q;
            head_vld_q     <= head_vld_d;
            head_q         <= head_d;
            skid_vld_q     <= skid_vld_d;
            skid_q         <= skid_d;
        end
    end

    assign out_valid   = head_vld_q;
    assign out_idx     = head_q.idx;
    assign out_data    = head_q.data;
    assign out_sof     = head_vld_q && (head_q.idx == '0);
    assign out_eof     = head_vld_q && (head_q.idx == AW'(ZONES-1));
    assign busy        = (state_q != IDLE);
    assign frame_short = frame_short_q;
    assign overrun_cnt = overrun_q;

endmodule
